// File: rtl/mult_share_arbiter.sv
// Shared shift-and-add multiplier serving two four-phase requesters.
// A round-robin arbiter picks one requester in IDLE, the operands are
// captured once, WIDTH add/shift iterations run, and the result is held
// in DONE until the granted requester lowers its request.
module mult_share_arbiter #(
  parameter int WIDTH = 6
) (
  input  logic               system_clk,
  input  logic               rst,
  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               done0,
  output logic               done1,
  output logic [2*WIDTH-1:0] product,
  output logic [1:0]         grant,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  // Counter value seen during the final RUN iteration.
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [PW-1:0]    x_reg, x_next;
  logic [WIDTH-1:0] y_reg, y_next;
  logic [PW-1:0]    product_reg, product_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [1:0]       grant_reg, grant_next;
  // Index of the requester served most recently; starts at 1 so that
  // requester 0 wins the first tie after reset.
  logic             last_reg, last_next;

  // Per-requester views so the arbiter and done logic index by requester.
  logic [1:0]       req_vec;
  logic [WIDTH-1:0] a_arr [2];
  logic [WIDTH-1:0] b_arr [2];
  logic [1:0]       done_vec;

  logic             winner;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic             granted_req;

  assign req_vec  = {req1, req0};
  assign a_arr[0] = a0;
  assign a_arr[1] = a1;
  assign b_arr[0] = b0;
  assign b_arr[1] = b1;

  // A requester sees done only while it owns the multiplier in DONE,
  // so at most one done line can ever be high.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_done
      assign done_vec[gi] = (state_reg == DONE) && grant_reg[gi];
    end
  endgenerate

  assign done0   = done_vec[0];
  assign done1   = done_vec[1];
  assign product = product_reg;
  assign grant   = grant_reg;
  assign busy    = (state_reg != IDLE);

  // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    winner = 1'b0;
    if (req_vec[0] && req_vec[1]) begin
      winner = ~last_reg;
    end else begin
      winner = req_vec[1];
    end
  end

  assign win_a       = a_arr[winner];
  assign win_b       = b_arr[winner];
  assign granted_req = |(grant_reg & req_vec);

  // Next-state and datapath update for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_next   = state_reg;
    x_next       = x_reg;
    y_next       = y_reg;
    product_next = product_reg;
    count_next   = count_reg;
    grant_next   = grant_reg;
    last_next    = last_reg;
    unique case (state_reg)
      IDLE: begin
        if (|req_vec) begin
          x_next       = {{WIDTH{1'b0}}, win_a};
          y_next       = win_b;
          product_next = '0;
          count_next   = '0;
          grant_next   = winner ? 2'b10 : 2'b01;
          state_next   = RUN;
        end
      end
      RUN: begin
        // Fixed-length loop: every iteration runs even when Y is already zero,
        // so latency never depends on operand values.
        if (y_reg[0]) begin
          product_next = product_reg + x_reg;
        end
        x_next     = x_reg << 1;
        y_next     = y_reg >> 1;
        count_next = count_reg + CW'(1);
        if (count_reg == LAST_ITER) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // Hold the result until the owner completes its handshake.
        if (!granted_req) begin
          state_next = IDLE;
          grant_next = 2'b00;
          last_next  = grant_reg[1];
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge system_clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      x_reg       <= '0;
      y_reg       <= '0;
      product_reg <= '0;
      count_reg   <= '0;
      grant_reg   <= 2'b00;
      last_reg    <= 1'b1;
    end else begin
      state_reg   <= state_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      product_reg <= product_next;
      count_reg   <= count_next;
      grant_reg   <= grant_next;
      last_reg    <= last_next;
    end
  end

endmodule
